// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset/exception vectors and next-PC source encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0004;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_RET  = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full silently replaces the oldest entry.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] entry_r [DEPTH];
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    ptr_m1_s;
    logic [PW-1:0]    ptr_nxt_s;
    logic [PW-1:0]    wr_idx_s;
    logic [PW:0]      cnt_r;
    logic [PW:0]      cnt_nxt_s;
    logic             wr_en_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;
    logic             ovf_r;
    logic             unf_r;

    assign ptr_m1_s = ptr_r - PTR_ONE;
    assign empty    = (cnt_r == '0);
    assign full     = (cnt_r == CNT_FULL);
    assign ovf      = ovf_r;
    assign unf      = unf_r;

    // Top of stack: newest entry sits just below the write pointer.
    always_comb begin
        top = '0;
        if (!empty) begin
            top = entry_r[ptr_m1_s];
        end else begin
            top = '0;
        end
    end

    // Next pointer/count/write decision for push, pop and the combined replace.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = 1'b0;
        unf_nxt_s = 1'b0;
        case ({push, pop})
            2'b10: begin
                wr_en_s   = 1'b1;
                ptr_nxt_s = ptr_r + PTR_ONE;
                if (full) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_nxt_s = 1'b1;
                end else begin
                    ptr_nxt_s = ptr_m1_s;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            2'b11: begin
                wr_en_s = 1'b1;
                if (empty) begin
                    // Nothing to pop: degrade to a plain push and flag the underflow.
                    ptr_nxt_s = ptr_r + PTR_ONE;
                    cnt_nxt_s = CNT_ONE;
                    unf_nxt_s = 1'b1;
                end else begin
                    wr_idx_s = ptr_m1_s;
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Stack storage, pointer, count and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            ptr_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (ena) begin
            if (wr_en_s) begin
                entry_r[wr_idx_s] <= push_data;
            end
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_nxt_s;
            unf_r <= unf_nxt_s;
        end else begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with prioritised next-PC selection, return-address stack and EPC.
module pc_ras_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic [WIDTH-1:0] epc
);

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(32'd4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(32'd3);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_empty_s;
    logic             push_s;
    logic             pop_s;
    pc_src_e          src_s;

    function automatic logic [WIDTH-1:0] align_f(input logic [WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    assign pc_plus4_s = pc_r + PC_STEP;
    // Exception and exception-return take over the cycle; the stack must not move.
    assign push_s     = call & ~exc & ~eret;
    assign pop_s      = ret  & ~exc & ~eret;

    // Priority encoder for the next-PC source.
    always_comb begin
        src_s = SRC_SEQ;
        if (exc) begin
            src_s = SRC_EXC;
        end else if (eret) begin
            src_s = SRC_ERET;
        end else if (ret) begin
            src_s = SRC_RET;
        end else if (call || jump) begin
            src_s = SRC_JMP;
        end else if (branch) begin
            src_s = SRC_BR;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_nxt_s = pc_plus4_s;
        case (src_s)
            SRC_EXC:  pc_nxt_s = EXC_VEC;
            SRC_ERET: pc_nxt_s = epc_r;
            SRC_RET:  pc_nxt_s = ras_empty_s ? align_f(ret_target) : align_f(ras_top_s);
            SRC_JMP:  pc_nxt_s = align_f(jump_target);
            SRC_BR:   pc_nxt_s = align_f(branch_target);
            SRC_SEQ:  pc_nxt_s = pc_plus4_s;
            default:  pc_nxt_s = pc_plus4_s;
        endcase
    end

    // PC and EPC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r  <= RESET_VEC;
            epc_r <= '0;
        end else if (ena) begin
            pc_r <= pc_nxt_s;
            if (src_s == SRC_EXC) begin
                epc_r <= pc_r;
            end
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_plus4_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

    assign pc        = pc_r;
    assign epc       = epc_r;
    assign pc_plus4  = pc_plus4_s;
    assign ras_top   = ras_top_s;
    assign ras_empty = ras_empty_s;

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised successor to the CPU's plain enable/reset PC register.
- Holds the program counter and selects the next PC from sequential, branch, jump, call, return, exception and exception-return sources.
- Contains a small circular return-address stack (RAS) and an EPC register.
- Sits at the front of the datapath, feeding instruction memory and the PC+4 link path.

Parameters:
- WIDTH, 32, address width in bits (≥ 8).
- RESET_VEC, 32'h0040_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0004, PC loaded on exception.
- RAS_DEPTH, 4, return-stack entries (power of two, ≥ 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- ena  in  1  advance enable; 0 = stall, all state holds.
- branch  in  1  take branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  take jump_target.
- call  in  1  jump to jump_target and push pc+4.
- jump_target  in  WIDTH  jump/call destination.
- ret  in  1  return: pop RAS.
- ret_target  in  WIDTH  register-file return address, used when RAS is empty.
- exc  in  1  exception: save pc to EPC, go to EXC_VEC.
- eret  in  1  exception return: pc <= EPC.
- pc  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc + 4, combinational.
- ras_top  out  WIDTH  top RAS entry; 0 when empty.
- ras_empty  out  1  stack holds no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_ovf  out  1  one-cycle pulse: push overwrote the oldest entry.
- ras_unf  out  1  one-cycle pulse: pop on an empty stack.
- epc  out  WIDTH  saved exception PC.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = RESET_VEC, epc = 0.
  - RAS count = 0, pointer = 0, all entries = 0.
  - ras_ovf = ras_unf = 0.
  - Release is sampled at the next rising edge.
- All state updates occur on the rising clk edge only when ena = 1.
- With ena = 0: pc, epc, RAS, and the pulse outputs hold (pulses forced 0).
- Next-PC priority, highest first:
  - exc: pc <= EXC_VEC, epc <= pc.
  - eret: pc <= epc.
  - ret: pc <= ras_top if the stack is non-empty, else ret_target.
  - call or jump: pc <= jump_target.
  - branch: pc <= branch_target.
  - otherwise: pc <= pc + 4.
- Target alignment: bits [1:0] of every target are forced to 0 when loaded into pc. EXC_VEC and RESET_VEC are used as given.
- Arithmetic: pc + 4 is modulo 2^WIDTH; the wrap from all-ones-minus-3 to 0 is legal, with no flag.
- RAS rules:
  - Actions apply only when the selected source is ret or call, or both (call and ret together with no exc/eret).
  - exc or eret suppresses all RAS action in that cycle.
  - Push (call): entry[ptr] <= pc + 4, ptr <= ptr + 1 (mod RAS_DEPTH), count <= min(count + 1, RAS_DEPTH).
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, ras_ovf = 1 for the next cycle.
  - Pop (ret) when non-empty: ptr <= ptr − 1, count <= count − 1.
  - Pop when empty: pc <= ret_target, count stays 0, ras_unf = 1 for the next cycle.
  - call and ret in the same cycle: the ret takes the PC (ras_top or ret_target). The top entry is replaced by pc + 4, so count and ptr are unchanged. If the stack is empty, this acts as a push plus ras_unf.
- Status outputs:
  - ras_top = entry[ptr − 1] when count > 0, else 0.
  - ras_empty = (count == 0); ras_full = (count == RAS_DEPTH).
- ras_ovf and ras_unf are registered pulses, each lasting one cycle after the causing edge.
- eret with epc never written returns to 0.
- Latency: the selection is visible on pc one edge after the request; there is no bubble.

Decomposition:
- Shared package cpu_pkg holds:
  - Constants RESET_VEC_DEF and EXC_VEC_DEF.
  - The next-PC source enum: SRC_SEQ, SRC_BR, SRC_JMP, SRC_RET, SRC_ERET, SRC_EXC.
- One natural sub-module, ras_stack: circular buffer with push, pop, top, count, ovf, unf; parametrised by WIDTH and RAS_DEPTH.

Test Plan:
- Reset then 3 enabled cycles:
  - pc reads 0x0040_0000, then 0x0040_0004, 0x0040_0008, 0x0040_000C.
  - Assert rst mid-cycle: pc = 0x0040_0000 immediately, without waiting for a clock edge.
- Stall: ena = 0 for 2 cycles with branch = 1, branch_target = 0x100 → pc unchanged. Then ena = 1 → pc = 0x100.
- Call/ret nesting:
  - At pc = 0x0040_0000, call to 0x200 → ras_top = 0x0040_0004.
  - At 0x200, call to 0x300 → ras_top = 0x204.
  - ret → pc = 0x204; ret → pc = 0x0040_0004, ras_empty = 1.
- Overflow/underflow (RAS_DEPTH = 4):
  - 5 calls from pcs P0..P4 → ras_ovf pulses after the 5th, ras_full = 1.
  - 4 rets return P4+4..P1+4.
  - 5th ret with ret_target = 0x3FF → pc = 0x3FC, ras_unf pulses.
- Exception priority: at pc = 0x500, assert exc, call, and branch together → pc = 0x4, epc = 0x500, RAS unchanged. Then eret → pc = 0x500.
- Simultaneous call+ret:
  - Stack = {0x104}, pc = 0x600 → pc = 0x104, ras_top = 0x604, count stays 1.
  - Wrap case: pc = 0xFFFF_FFFC, sequential step → pc = 0x0.
